team_06_i2s_stereo_tx: RTL and testbench
========================================

// Module: team_06_i2s_stereo_tx
// PURPOSE
//  Parametrised stereo I2S transmitter; next generation of the team's 8-bit mono serialiser.
//  Accepts stereo samples over a valid/ready port into a small FIFO.
//  Generates bclk and lrclk from clk and shifts samples out MSB-first in standard I2S
//  (Philips) framing, with underrun detection. Sits between the audio datapath and the
//  external DAC pins.
// PARAMETERS
//  DATA_W      8  bits per channel slot; >=2
//  CLK_DIV     2  clk cycles per bclk half-period; >=1
//  FIFO_DEPTH  4  stereo-sample FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1                    system clock
//  rst        in   1                    reset, asynchronous, active-high
//  en         in   1                    transmit enable
//  s_data     in   2*DATA_W             {left, right}; left in upper DATA_W bits
//  s_valid    in   1                    s_data valid
//  s_ready    out  1                    FIFO can accept (= !full)
//  bclk       out  1                    I2S bit clock
//  lrclk      out  1                    word select; 0 = left, 1 = right
//  sdata      out  1                    I2S serial data
//  underrun   out  1                    1-clk pulse: frame started with FIFO empty
//  fifo_level out  $clog2(FIFO_DEPTH)+1 current FIFO occupancy
// BEHAVIOUR
//  Reset values: bclk=0, lrclk=0, sdata=0, underrun=0, fifo_level=0, s_ready=1.
//  - All bit counters reset to idle: bit_cnt = 2*DATA_W-1, div_cnt = 0.
//  FIFO push:
//  - Push when s_valid && s_ready. s_ready reflects pre-pop fullness, so there is no
//    push-through when full.
//  - Push and pop in the same clk: both take effect; level unchanged.
//  - The FIFO accepts pushes regardless of en.
//  bclk generation (en=1):
//  - div_cnt counts 0..CLK_DIV-1; bclk register toggles when div_cnt==CLK_DIV-1.
//  - bclk period = 2*CLK_DIV clk cycles.
//  Falling-edge event:
//  - Defined as the clk edge where bclk goes 1->0. bclk, lrclk and sdata all update
//    on that same clk edge (all registered).
//  - On this event bit_cnt advances mod 2*DATA_W.
//  - On wrap (2*DATA_W-1 -> 0): pop FIFO into the frame shift register.
//  - If the FIFO is empty at wrap: load all zeros and pulse underrun for 1 clk.
//  Frame output, with bit_cnt b after the event:
//  - sdata = frame bit b; frame bit 0 = left MSB, bit DATA_W = right MSB.
//  - lrclk = 1 for b in [DATA_W-1, 2*DATA_W-2], else 0, so lrclk leads each channel
//    MSB by one bclk (I2S delay).
//  Frame timing:
//  - Frames are back-to-back with no gaps.
//  - lrclk period = 2*DATA_W bclk.
//  - The receiver samples sdata on bclk rising edges.
//  en=0 (takes effect on the next clk):
//  - bclk, lrclk and sdata driven 0; div_cnt=0; bit_cnt set to idle (2*DATA_W-1).
//  - A frame in flight is dropped, never resumed. FIFO contents and level are retained.
//  Re-enable: the first falling event wraps bit_cnt and pops the next sample, so a
//  fresh frame always starts at the left MSB.
//  rst mid-frame: everything returns to reset values immediately (async); FIFO emptied.
// TESTING
//  1 rst asserted mid-frame -> bclk/lrclk/sdata/underrun=0, fifo_level=0, s_ready=1 same cycle.
//  2 DATA_W=8, CLK_DIV=2: push 16'hA53C, en=1 -> bclk period 4 clk;
//    sdata on rising edges reads 1010_0101_0011_1100;
//    lrclk=1 for bit_cnt 7..14; underrun stays 0.
//  3 en=0: push 4 samples -> fifo_level=4, s_ready=0; 5th push ignored, level stays 4.
//  4 en=1 with FIFO empty -> sdata all zeros, underrun pulse of exactly 1 clk at each wrap.
//  5 Push 2 samples, en=1 -> two consecutive frames with no gap; lrclk period 16 bclk;
//    third frame underruns.
//  6 Drop en at bit 5 of frame 1 -> outputs 0 next clk, level unchanged;
//    re-enable -> next frame starts at left MSB of the next FIFO sample.

Source files
------------

// File: rtl/team_06_i2s_stereo_tx.sv
// Stereo I2S (Philips) transmitter: sample FIFO, bclk/lrclk generation and MSB-first
// serialiser with underrun flag on frames that start while the FIFO is empty.
module team_06_i2s_stereo_tx #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [2*DATA_W-1:0]           s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int FW = 2 * DATA_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FW);
  localparam logic [BW-1:0] BIT_IDLE = BW'(FW - 1);
  localparam logic [BW-1:0] LR_LO    = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LR_HI    = BW'(FW - 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] nxt_bit;
  logic [FW-1:0] shift_reg;
  logic [FW-1:0] nxt_frame;
  logic          push;
  logic          pop;
  logic          fall;
  logic          wrap;
  logic          empty;

  assign s_ready   = (fifo_level != LVL_FULL);
  assign push      = s_valid && s_ready;
  assign empty     = (fifo_level == '0);
  assign fall      = en && bclk && (div_cnt == DIV_LAST);
  assign nxt_bit   = (bit_cnt == BIT_IDLE) ? '0 : bit_cnt + 1'b1;
  assign wrap      = fall && (nxt_bit == '0);
  assign pop       = wrap && !empty;
  // An empty FIFO at frame start sends a silent frame.
  assign nxt_frame = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      div_cnt    <= '0;
      bit_cnt    <= BIT_IDLE;
      shift_reg  <= '0;
      bclk       <= 1'b0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;

      if (!en) begin
        div_cnt <= '0;
        bit_cnt <= BIT_IDLE;
        bclk    <= 1'b0;
        lrclk   <= 1'b0;
        sdata   <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        bclk    <= !bclk;
        if (fall) begin
          bit_cnt <= nxt_bit;
          // lrclk switches one bclk ahead of each channel MSB
          lrclk   <= (nxt_bit >= LR_LO) && (nxt_bit <= LR_HI);
          if (wrap) begin
            sdata     <= nxt_frame[FW-1];
            shift_reg <= nxt_frame << 1;
            underrun  <= empty;
          end else begin
            sdata     <= shift_reg[FW-1];
            shift_reg <= shift_reg << 1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_team_06_i2s_stereo_tx.sv
// Bench for team_06_i2s_stereo_tx: directed scenarios plus random push/run/drop trials,
// checked every clk against a frame-level model derived from cycle arithmetic.
module tb_team_06_i2s_stereo_tx;
  localparam int W  = 8;
  localparam int CD = 2;
  localparam int D  = 4;
  localparam int FW = 2 * W;
  localparam int FC = 2 * CD * FW;  // clk cycles per frame

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [FW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          underrun;
  logic [2:0]    fifo_level;

  int total = 0;
  int bad   = 0;
  logic [FW-1:0] q[$];
  logic [FW-1:0] rx;

  team_06_i2s_stereo_tx #(.DATA_W(W), .CLK_DIV(CD), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .underrun(underrun), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [FW-1:0] d);
    chk("s_ready_pre", 32'(s_ready), 32'(q.size() < D));
    s_data  = d;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    if (q.size() < D) q.push_back(d);
    chk("level_push", 32'(fifo_level), 32'(q.size()));
  endtask

  // Edge n after enabling: bclk = (n/CD)%2; falling events at multiples of 2*CD;
  // after f falls the frame bit is (f-1)%FW and each new frame pops the queue.
  task automatic run_en(input int ncyc);
    int f;
    int b;
    logic [FW-1:0] cur;
    logic e_ur;
    logic e_sd;
    logic e_lr;
    cur = '0;
    rx  = '0;
    en  = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      step();
      e_ur = 1'b0;
      f = n / (2 * CD);
      if (n % (2 * CD) == 0 && (f - 1) % FW == 0) begin
        if (q.size() > 0) cur = q.pop_front();
        else begin
          cur  = '0;
          e_ur = 1'b1;
        end
      end
      if (f == 0) begin
        e_sd = 1'b0;
        e_lr = 1'b0;
      end else begin
        b    = (f - 1) % FW;
        e_sd = cur[FW-1-b];
        e_lr = (b >= W - 1) && (b <= FW - 2);
      end
      chk("bclk", 32'(bclk), 32'((n / CD) % 2));
      chk("lrclk", 32'(lrclk), 32'(e_lr));
      chk("sdata", 32'(sdata), 32'(e_sd));
      chk("underrun", 32'(underrun), 32'(e_ur));
      chk("level_run", 32'(fifo_level), 32'(q.size()));
      chk("s_ready_run", 32'(s_ready), 32'(q.size() < D));
      if (n % (2 * CD) == CD && f >= 1 && f <= FW) rx = {rx[FW-2:0], sdata};
    end
  endtask

  task automatic dis();
    en = 1'b0;
    step();
    chk("dis_bclk", 32'(bclk), 32'd0);
    chk("dis_lrclk", 32'(lrclk), 32'd0);
    chk("dis_sdata", 32'(sdata), 32'd0);
    chk("dis_underrun", 32'(underrun), 32'd0);
    chk("dis_level", 32'(fifo_level), 32'(q.size()));
  endtask

  initial begin
    int k;
    int ncyc;
    rst     = 1'b1;
    en      = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    #12;
    chk("rst_bclk", 32'(bclk), 32'd0);
    chk("rst_lrclk", 32'(lrclk), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    step();

    // single sample, one full frame then an underrun at the next wrap
    push(16'hA53C);
    run_en(4 + FC + 2);
    chk("rx_word", 32'(rx), 32'h0000A53C);
    dis();

    // fill while disabled, overflow attempt ignored
    for (int i = 0; i < 5; i++) push(FW'($urandom));
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_s_ready", 32'(s_ready), 32'd0);

    // drain four frames then run on empty
    run_en(4 + 5 * FC + 6);
    dis();

    // two back-to-back frames, third underruns
    push(FW'($urandom));
    push(FW'($urandom));
    run_en(4 + 2 * FC + 10);
    dis();

    // drop at bit 5 of the first frame, then resume with the next sample
    for (int i = 0; i < 3; i++) push(FW'($urandom));
    run_en(25);
    dis();
    chk("drop_level", 32'(fifo_level), 32'd2);
    run_en(4 + FC);
    dis();

    for (int t = 0; t < 8; t++) begin
      k = $urandom_range(0, 5);
      for (int i = 0; i < k; i++) push(FW'($urandom));
      ncyc = $urandom_range(1, 3 * FC);
      run_en(ncyc);
      dis();
    end

    // async reset mid-frame
    while (q.size() < 2) push(FW'($urandom));
    run_en(40);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_bclk", 32'(bclk), 32'd0);
    chk("mid_rst_lrclk", 32'(lrclk), 32'd0);
    chk("mid_rst_sdata", 32'(sdata), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
    #2;
    rst = 1'b0;
    step();
    push(16'h1234);
    run_en(4 + FC);
    chk("post_rst_rx", 32'(rx), 32'h00001234);
    dis();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
